// File: rtl/sysbus_memmap.sv
// SysBus memory-mapped slave: decodes ALE/nME/nOE/nWE strobes into single
// accesses to an on-chip word RAM and a small I/O register bank.
module sysbus_memmap #(
    parameter int          RAM_AW  = 10,
    parameter logic [15:0] IO_BASE = 16'hFFF0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] SysBusIn,
    output logic [15:0] SysBusOut,
    output logic        SysBusOe,
    input  logic        ALE,
    input  logic        nME,
    input  logic        nOE,
    input  logic        nWE,
    input  logic        ENB,
    input  logic [7:0]  Switches,
    output logic [7:0]  Leds,
    output logic        BusError
);

    typedef enum logic [2:0] {IDLE, ADDR, SEL, RD, WDONE} busState_t;

    busState_t   state, stateNext;
    logic [15:0] addr;
    logic [15:0] rData;
    logic [7:0]  ledReg;
    logic        errFlag;
    logic [15:0] cycleCount;
    logic [7:0]  swMeta, swSync;
    logic [15:0] mem [2**RAM_AW];

    logic rdStb, wrStb, selStb, illStb;
    logic doRead, doWrite, setErr;
    logic isRam, isIo, readMapped, writeMapped, clrErr;
    logic [3:0]        ioOff;
    logic [RAM_AW-1:0] ramIdx;
    logic [15:0]       readValue;

    assign rdStb  = !nME && !nOE &&  nWE;
    assign wrStb  = !nME &&  nOE && !nWE;
    assign selStb = !nME &&  nOE &&  nWE;
    assign illStb = !nME && !nOE && !nWE;

    // Address decode; the I/O window is assumed 16-word aligned.
    assign isRam       = (addr[15:RAM_AW] == '0);
    assign isIo        = (addr[15:4] == IO_BASE[15:4]);
    assign ioOff       = addr[3:0];
    assign ramIdx      = addr[RAM_AW-1:0];
    assign readMapped  = isRam || (isIo && (ioOff < 4'd4));
    assign writeMapped = isRam || (isIo && ((ioOff == 4'd0) || (ioOff == 4'd3)))
                         || (isIo && ((ioOff == 4'd1) || (ioOff == 4'd2)));
    assign clrErr      = doWrite && isIo && (ioOff == 4'd3) && SysBusIn[0];

    always_comb begin
        readValue = 16'h0000;
        if (isRam) begin
            readValue = mem[ramIdx];
        end else if (isIo) begin
            case (ioOff)
                4'd0:    readValue = {8'h00, ledReg};
                4'd1:    readValue = {8'h00, swSync};
                4'd2:    readValue = cycleCount;
                4'd3:    readValue = {15'h0000, errFlag};
                default: readValue = 16'h0000;
            endcase
        end
    end

    // ALE overrides everything; otherwise each latched address yields at most one access.
    always_comb begin
        stateNext = state;
        doRead    = 1'b0;
        doWrite   = 1'b0;
        setErr    = 1'b0;
        if (ALE) begin
            stateNext = ADDR;
        end else begin
            case (state)
                ADDR, SEL: begin
                    if (rdStb) begin
                        doRead    = 1'b1;
                        setErr    = !readMapped;
                        stateNext = RD;
                    end else if (wrStb) begin
                        doWrite   = 1'b1;
                        setErr    = !writeMapped;
                        stateNext = WDONE;
                    end else if (selStb) begin
                        stateNext = SEL;
                    end else if (illStb) begin
                        setErr    = 1'b1;
                        stateNext = WDONE;
                    end
                end
                RD: begin
                    if (nME) stateNext = IDLE;
                    else if (wrStb || illStb) setErr = 1'b1;
                end
                WDONE: begin
                    if (nME) stateNext = IDLE;
                end
                default: begin
                    if (rdStb || wrStb || illStb) setErr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            addr       <= 16'h0000;
            rData      <= 16'h0000;
            ledReg     <= 8'h00;
            errFlag    <= 1'b0;
            cycleCount <= 16'h0000;
            swMeta     <= 8'h00;
            swSync     <= 8'h00;
        end else begin
            state      <= stateNext;
            cycleCount <= cycleCount + 16'd1;
            swMeta     <= Switches;
            swSync     <= swMeta;
            if (ALE) addr <= SysBusIn;
            if (doRead) rData <= readMapped ? readValue : 16'h0000;
            if (doWrite && isIo && (ioOff == 4'd0)) ledReg <= SysBusIn[7:0];
            // A new error on the same edge as a clear must leave the flag set.
            if (setErr) errFlag <= 1'b1;
            else if (clrErr) errFlag <= 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset && doWrite && isRam) mem[ramIdx] <= SysBusIn;
    end

    assign SysBusOe  = (state == RD) && ENB;
    assign SysBusOut = SysBusOe ? rData : 16'h0000;
    assign Leds      = ledReg;
    assign BusError  = errFlag;

endmodule

// File: tb/tb_sysbus_memmap.sv
// Randomised self-checking bench for sysbus_memmap against a
// behavioural address-map model.
module tb_sysbus_memmap;

    localparam logic [15:0] IO_BASE = 16'hFFF0;
    localparam int          RAM_WORDS = 1024;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] SysBusIn = 16'h0000;
    logic [15:0] SysBusOut;
    logic        SysBusOe;
    logic        ALE = 1'b0, nME = 1'b1, nOE = 1'b1, nWE = 1'b1, ENB = 1'b0;
    logic [7:0]  Switches = 8'h00;
    logic [7:0]  Leds;
    logic        BusError;

    int compared = 0;
    int mismatched = 0;
    int edges = 0;

    logic [15:0] ramModel [RAM_WORDS];
    bit          ramValid [RAM_WORDS];
    logic [7:0]  ledModel = 8'h00;
    logic        errModel = 1'b0;
    logic [7:0]  swModel = 8'h00;

    sysbus_memmap #(.RAM_AW(10), .IO_BASE(IO_BASE)) dut (
        .Clock(Clock), .Reset(Reset), .SysBusIn(SysBusIn), .SysBusOut(SysBusOut),
        .SysBusOe(SysBusOe), .ALE(ALE), .nME(nME), .nOE(nOE), .nWE(nWE), .ENB(ENB),
        .Switches(Switches), .Leds(Leds), .BusError(BusError)
    );

    always #5 Clock = ~Clock;

    // Rising edges since reset was released: what the cycle counter should hold.
    always @(posedge Clock or posedge Reset) begin
        if (Reset) edges = 0;
        else edges = edges + 1;
    end

    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic busIdle();
        ALE = 1'b0; nME = 1'b1; nOE = 1'b1; nWE = 1'b1; ENB = 1'b0;
    endtask

    function automatic void modelWrite(input logic [15:0] a, input logic [15:0] d);
        if (a < RAM_WORDS) begin
            ramModel[a] = d;
            ramValid[a] = 1'b1;
        end else if (a == IO_BASE) ledModel = d[7:0];
        else if (a == IO_BASE + 16'd3) begin
            if (d[0]) errModel = 1'b0;
        end else if (a == IO_BASE + 16'd1 || a == IO_BASE + 16'd2) begin
        end else errModel = 1'b1;
    endfunction

    function automatic logic [15:0] modelRead(input logic [15:0] a, input int cnt);
        logic [15:0] cntBits;
        cntBits = 16'(cnt);
        if (a < RAM_WORDS) return ramModel[a];
        if (a == IO_BASE) return {8'h00, ledModel};
        if (a == IO_BASE + 16'd1) return {8'h00, swModel};
        if (a == IO_BASE + 16'd2) return cntBits;
        if (a == IO_BASE + 16'd3) return {15'h0000, errModel};
        errModel = 1'b1;
        return 16'h0000;
    endfunction

    task automatic busWrite(input logic [15:0] a, input logic [15:0] d);
        ALE = 1'b1; SysBusIn = a; cycle();
        ALE = 1'b0; nME = 1'b0; cycle();
        nWE = 1'b0; SysBusIn = d; cycle();
        busIdle(); cycle();
        modelWrite(a, d);
    endtask

    task automatic busRead(input logic [15:0] a, output logic [15:0] data,
                           output logic oeBefore, output logic oeDuring, output int issueCnt);
        ALE = 1'b1; SysBusIn = a; cycle();
        ALE = 1'b0; nME = 1'b0; nOE = 1'b0;
        issueCnt = edges;
        cycle();
        #1 oeBefore = SysBusOe;
        ENB = 1'b1;
        #1 data = SysBusOut; oeDuring = SysBusOe;
        cycle();
        busIdle(); cycle();
    endtask

    task automatic test_reset();
        ENB = 1'b1; #1;
        compared++;
        if (SysBusOe !== 1'b0 || SysBusOut !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL reset_bus: oe=%b out=%h want oe=0 out=0000", SysBusOe, SysBusOut);
        end
        compared++;
        if (Leds !== 8'h00 || BusError !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_regs: leds=%h err=%b want 00/0", Leds, BusError);
        end
        busIdle();
    endtask

    task automatic test_ram_basic();
        logic [15:0] d; logic ob, od; int c;
        busWrite(16'h0005, 16'h1234);
        busRead(16'h0005, d, ob, od, c);
        compared++;
        if (d !== 16'h1234 || ob !== 1'b0 || od !== 1'b1 || BusError !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ram_basic: data=%h oe=%b/%b err=%b want 1234 0/1 0", d, ob, od, BusError);
        end
    endtask

    task automatic test_leds();
        logic [15:0] d; logic ob, od; int c;
        ALE = 1'b1; SysBusIn = IO_BASE; cycle();
        ALE = 1'b0; nME = 1'b0; cycle();
        nWE = 1'b0; SysBusIn = 16'h00A5; cycle();
        modelWrite(IO_BASE, 16'h00A5);
        compared++;
        if (Leds !== 8'hA5) begin
            mismatched++;
            $display("[TB] FAIL leds_write: leds=%h want a5", Leds);
        end
        busIdle(); cycle();
        busRead(IO_BASE, d, ob, od, c);
        compared++;
        if (d !== modelRead(IO_BASE, c) || od !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL leds_read: data=%h oe=%b want 00a5 1", d, od);
        end
    endtask

    task automatic test_errors();
        logic [15:0] d, old; logic ob, od; int c;
        busRead(16'h8000, d, ob, od, c);
        void'(modelRead(16'h8000, c));
        compared++;
        if (d !== 16'h0000 || BusError !== 1'b1 || errModel !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL unmapped_read: data=%h err=%b want 0000 1", d, BusError);
        end
        busWrite(IO_BASE + 16'd3, 16'h0001);
        compared++;
        if (BusError !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL status_clear: err=%b want 0", BusError);
        end
        old = ramModel[5];
        ALE = 1'b1; SysBusIn = 16'h0005; cycle();
        ALE = 1'b0; nME = 1'b0; nOE = 1'b0; nWE = 1'b0; SysBusIn = 16'hDEAD; cycle();
        busIdle(); cycle();
        errModel = 1'b1;
        compared++;
        if (BusError !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL illegal_err: err=%b want 1", BusError);
        end
        busRead(16'h0005, d, ob, od, c);
        compared++;
        if (d !== old) begin
            mismatched++;
            $display("[TB] FAIL illegal_noram: data=%h want %h", d, old);
        end
        busWrite(IO_BASE + 16'd3, 16'h0001);
    endtask

    task automatic test_double_strobe();
        logic [15:0] d; logic ob, od; int c;
        ALE = 1'b1; SysBusIn = 16'h0011; cycle();
        ALE = 1'b0; nME = 1'b0; cycle();
        nWE = 1'b0; SysBusIn = 16'h1111; cycle();
        SysBusIn = 16'h2222; cycle();
        busIdle(); cycle();
        modelWrite(16'h0011, 16'h1111);
        busRead(16'h0011, d, ob, od, c);
        compared++;
        if (d !== 16'h1111 || BusError !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL double_strobe: data=%h err=%b want 1111 0", d, BusError);
        end
    endtask

    task automatic test_abort();
        busWrite(16'h0020, 16'hAAAA);
        busWrite(16'h0021, 16'h5555);
        ALE = 1'b1; SysBusIn = 16'h0020; cycle();
        ALE = 1'b0; nME = 1'b0; nOE = 1'b0; cycle();
        ALE = 1'b1; SysBusIn = 16'h0021; cycle();
        ALE = 1'b0; nOE = 1'b1; ENB = 1'b1; #1;
        compared++;
        if (SysBusOe !== 1'b0 || SysBusOut !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL abort_nodrive: oe=%b out=%h want 0 0000", SysBusOe, SysBusOut);
        end
        cycle();
        ENB = 1'b0; nOE = 1'b0; cycle();
        ENB = 1'b1; #1;
        compared++;
        if (SysBusOe !== 1'b1 || SysBusOut !== ramModel[16'h0021]) begin
            mismatched++;
            $display("[TB] FAIL abort_newread: oe=%b out=%h want 1 %h", SysBusOe, SysBusOut, ramModel[16'h0021]);
        end
        cycle();
        busIdle(); cycle();
    endtask

    task automatic test_switches();
        logic [15:0] d; logic ob, od; int c;
        for (int i = 0; i < 3; i++) begin
            swModel = (i == 0) ? 8'h3C : 8'($urandom);
            Switches = swModel;
            cycle(); cycle(); cycle();
            busRead(IO_BASE + 16'd1, d, ob, od, c);
            compared++;
            if (d !== modelRead(IO_BASE + 16'd1, c)) begin
                mismatched++;
                $display("[TB] FAIL switches: data=%h want %h", d, {8'h00, swModel});
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a, d, exp; logic ob, od; int c, kind;
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 4));
            if (kind == 0 || kind == 1) begin
                a = 16'($urandom_range(0, RAM_WORDS - 1));
                busWrite(a, 16'($urandom));
            end else if (kind == 2) begin
                a = 16'($urandom_range(0, RAM_WORDS - 1));
                if (!ramValid[a]) busWrite(a, 16'($urandom));
                busRead(a, d, ob, od, c);
                exp = modelRead(a, c);
                compared++;
                if (d !== exp || ob !== 1'b0 || od !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL rand_ram_read @%h: data=%h oe=%b/%b want %h 0/1", a, d, ob, od, exp);
                end
            end else if (kind == 3) begin
                a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'h0400, 16'hFFEF))
                                                 : IO_BASE + 16'($urandom_range(4, 15));
                if ($urandom_range(0, 1) == 0) begin
                    busRead(a, d, ob, od, c);
                    exp = modelRead(a, c);
                    compared++;
                    if (d !== exp) begin
                        mismatched++;
                        $display("[TB] FAIL rand_unmapped_read @%h: data=%h want %h", a, d, exp);
                    end
                end else busWrite(a, 16'($urandom));
            end else begin
                busWrite(IO_BASE + 16'd3, 16'($urandom));
            end
            compared++;
            if (BusError !== errModel || Leds !== ledModel) begin
                mismatched++;
                $display("[TB] FAIL rand_status #%0d: err=%b leds=%h want %b %h", i, BusError, Leds, errModel, ledModel);
            end
        end
    endtask

    task automatic test_reset_midread();
        logic [15:0] d; logic ob, od; int c;
        busWrite(IO_BASE, 16'h005A);
        busWrite(16'h0007, 16'hBEEF);
        busWrite(16'h9000, 16'h0000);
        ALE = 1'b1; SysBusIn = 16'h0007; cycle();
        ALE = 1'b0; nME = 1'b0; nOE = 1'b0; cycle();
        ENB = 1'b1; #1;
        compared++;
        if (SysBusOe !== 1'b1 || SysBusOut !== 16'hBEEF) begin
            mismatched++;
            $display("[TB] FAIL pre_reset_read: oe=%b out=%h want 1 beef", SysBusOe, SysBusOut);
        end
        Reset = 1'b1; #1;
        compared++;
        if (SysBusOe !== 1'b0 || Leds !== 8'h00 || BusError !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_midread: oe=%b leds=%h err=%b want 0 00 0", SysBusOe, Leds, BusError);
        end
        busIdle(); cycle(); cycle();
        Reset = 1'b0;
        ledModel = 8'h00; errModel = 1'b0;
        busRead(IO_BASE + 16'd2, d, ob, od, c);
        compared++;
        if (d !== modelRead(IO_BASE + 16'd2, c)) begin
            mismatched++;
            $display("[TB] FAIL count_after_reset: data=%h want %h", d, 16'(c));
        end
        busRead(16'h0007, d, ob, od, c);
        compared++;
        if (d !== 16'hBEEF) begin
            mismatched++;
            $display("[TB] FAIL ram_retained: data=%h want beef", d);
        end
    endtask

    task automatic test_counter_wrap();
        logic [15:0] d; logic ob, od; int c;
        repeat (65536 + 37) cycle();
        busRead(IO_BASE + 16'd2, d, ob, od, c);
        compared++;
        if (c < 65536 || d !== modelRead(IO_BASE + 16'd2, c)) begin
            mismatched++;
            $display("[TB] FAIL counter_wrap: data=%h want %h (issue edge %0d)", d, 16'(c), c);
        end
    endtask

    initial begin
        busIdle();
        for (int i = 0; i < RAM_WORDS; i++) begin
            ramModel[i] = 16'h0000;
            ramValid[i] = 1'b0;
        end
        cycle(); cycle();
        test_reset();
        Reset = 1'b0;
        cycle();
        test_ram_basic();
        test_leds();
        test_errors();
        test_double_strobe();
        test_abort();
        test_switches();
        test_random();
        test_reset_midread();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sysbus_memmap.md
# sysbus_memmap

Memory-mapped bus slave sitting directly downstream of the processor control FSM on the shared 16-bit SysBus. It decodes the control strobes (ALE, nME, nOE, nWE, ENB) into address-latch, read and write transactions, and serves them from an on-chip synchronous word RAM and a small I/O register bank. The I/O bank holds LEDs, synchronised switches, a cycle counter and a sticky bus-error status. It turns each fetch, LDW or STW strobe sequence into exactly one memory access.

## Interface
- RAM_AW, 10: RAM address width. RAM occupies word addresses 0 to 2^RAM_AW-1.
- IO_BASE, 16'hFFF0: base of the 16-word I/O window.
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- SysBusIn  in  16  SysBus value, used as address when ALE=1 and as write data during a write strobe.
- SysBusOut  out  16  read data; 0 whenever SysBusOe=0.
- SysBusOe  out  1  block drives SysBus this cycle.
- ALE  in  1  address latch enable.
- nME  in  1  memory select, active low.
- nOE  in  1  read strobe, active low.
- nWE  in  1  write strobe, active low.
- ENB  in  1  processor samples the bus this cycle.
- Switches  in  8  asynchronous board inputs.
- Leds  out  8  LED register.
- BusError  out  1  sticky error flag; equals status bit 0.

## Operation
- **Address map** (word addressed):
  - RAM at 0..2^RAM_AW-1.
  - IO_BASE+0: LED register, R/W, low 8 bits; reads return zero-extended.
  - IO_BASE+1: Switches, read-only, synchronised by 2 flops.
  - IO_BASE+2: CycleCount, read-only.
  - IO_BASE+3: Status, bit0 = error. Writing data with bit0=1 clears the error; otherwise no effect.
  - All other addresses are unmapped: reads return 0, writes are ignored, and both set the error.
- **Strobe decode**, only when nME=0:
  - read = nOE=0 & nWE=1
  - write = nWE=0 & nOE=1
  - select = both strobes high
  - illegal = both strobes low
- **FSM states:** IDLE, ADDR, SEL, RD, WDONE.
- ALE=1 in any state latches SysBusIn into Addr and moves to ADDR. ALE has highest priority and aborts any transaction in progress without a write.
- **ADDR or SEL**, per decoded strobe:
  - read → RD; read data registered into RData this edge.
  - write → commit SysBusIn to the target this edge → WDONE.
  - select → SEL.
  - illegal → set error → WDONE.
  - nME=1 → remain in the current state.
- **RD:**
  - SysBusOe = ENB (combinational).
  - nME=1 → IDLE.
  - A write or illegal strobe sets error and is otherwise ignored.
- **WDONE:**
  - Further strobes are ignored: exactly one write per latched address.
  - nME=1 → IDLE.
- **IDLE:** a read, write or illegal strobe with nME=0 and no ALE sets error; no access, no drive.
- **CycleCount:** 16-bit free-running counter, +1 every cycle, wraps 16'hFFFF → 0. The value returned is the one present at the read-issue edge.
- **Error set vs. clear:** if the Status clear-write and a new error occur on the same edge, the set wins.
- **Reset values:** state IDLE, Addr=0, RData=0, Leds=0, error=0, CycleCount=0, synchroniser flops=0, SysBusOe=0, SysBusOut=0. RAM contents are not reset.

## Timing
- Address phase: ALE=1 at edge N means Addr is valid from N.
- Read: read strobe at edge N+1 registers RData. ENB=1 in cycle N+2 drives SysBusOut=RData and SysBusOe=1. This gives a 1-cycle read latency, which matches the fetch and LDW sequences (ALE, read, ENB, deselect).
- Write: the target is updated at the first write-strobe edge. Leds and RAM are visible from the next cycle.
- ENB outside RD never drives the bus.
- SysBusOe is combinational from state and ENB. SysBusOut is 0 when not driving.
- Reset asserted mid-transaction takes effect immediately. Any write not yet clocked is lost; a write already clocked is retained in RAM.

## Test plan
- Write then read RAM:
  - Write: ALE with 16'h0005; select cycle; write strobe with 16'h1234; deselect.
  - Read: ALE with 16'h0005; read; ENB.
  - Required: SysBusOut=16'h1234 and SysBusOe=1 only in the ENB cycle; BusError=0.
- Write 16'h00A5 to IO_BASE+0. Required: Leds=8'hA5 from the next cycle; a read-back returns 16'h00A5.
- Unmapped and illegal accesses:
  - Read 16'h8000 with RAM_AW=10. Required: SysBusOut=0 on ENB and BusError=1.
  - Write 16'h0001 to IO_BASE+3. Required: BusError=0.
  - Strobe nOE=0, nWE=0 after ALE. Required: BusError=1 and no RAM change.
- Double strobe and abort:
  - Hold the write strobe for 2 cycles with data 16'h1111 then 16'h2222. Required: RAM holds 16'h1111.
  - Assert ALE to a new address mid-read before ENB. Required: no bus drive until a new read completes.
- Reset and counter:
  - Assert Reset in the RD state. Required: SysBusOe=0 immediately, Leds=0, BusError=0, CycleCount=0.
  - After 65536 cycles out of reset, read IO_BASE+2. Required: the value read reflects the wrap, small relative to the read-issue cycle count.
- Switches: drive Switches=8'h3C, wait 3 cycles, read IO_BASE+1. Required: 16'h003C.
